// File: rtl/alu_ex_stage.sv
// Execute stage: ALU plus branch decision, registered into an EX/MEM slot
// with a one-entry skid buffer so a MEM stall never reaches ID combinationally.
module alu_ex_stage #(
    parameter int XLEN = 32,
    parameter int TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alucon,
    input  logic [2:0]      funct3,
    input  logic            is_branch,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [TAGW-1:0] rd_tag,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            br_taken,
    output logic            illegal,
    output logic [TAGW-1:0] out_tag
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b1000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_SRA  = 4'b1101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111
    } alu_op_e;

    // One op's worth of EX/MEM payload, shared by the main slot and the skid slot.
    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            br;
        logic            ill;
        logic [TAGW-1:0] tag;
    } slot_t;

    logic [SHW-1:0] shamt;
    logic [XLEN-1:0] alu_r;
    logic            code_bad;
    logic            br_bad;
    logic            br_dec;
    slot_t           incoming;
    slot_t           main_q;
    slot_t           skid_q;
    logic            skid_valid;
    logic            in_fire;
    logic            main_open;

    assign shamt = op_b[SHW-1:0];

    // ALU: decode alucon into a result; undefined codes yield zero and flag illegal.
    always_comb begin
        alu_r    = '0;
        code_bad = 1'b0;
        case (alucon)
            ALU_ADD:  alu_r = op_a + op_b;
            ALU_SUB:  alu_r = op_a - op_b;
            ALU_SLL:  alu_r = op_a << shamt;
            ALU_SLT:  alu_r = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_r = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  alu_r = op_a ^ op_b;
            ALU_SRL:  alu_r = op_a >> shamt;
            ALU_SRA:  alu_r = $signed(op_a) >>> shamt;
            ALU_OR:   alu_r = op_a | op_b;
            ALU_AND:  alu_r = op_a & op_b;
            default: begin
                alu_r    = '0;
                code_bad = 1'b1;
            end
        endcase
    end

    // Branch decision derived from the ALU result; funct3 010/011 are not branches.
    always_comb begin
        br_dec = 1'b0;
        br_bad = 1'b0;
        if (is_branch) begin
            case (funct3)
                3'b000:         br_dec = (alu_r == '0);
                3'b001:         br_dec = (alu_r != '0);
                3'b100, 3'b110: br_dec = alu_r[0];
                3'b101, 3'b111: br_dec = ~alu_r[0];
                default:        br_bad = 1'b1;
            endcase
        end
    end

    assign incoming  = '{res: alu_r, br: br_dec, ill: code_bad | br_bad, tag: rd_tag};
    assign in_fire   = in_valid & in_ready;
    assign main_open = ~out_valid | out_ready;

    // Main/skid slot update: skid always drains into main first so order is kept;
    // in_ready is registered as the inverse of the next skid occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (main_open) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= in_fire;
                in_ready   <= ~in_fire;
                if (in_fire) begin
                    skid_q <= incoming;
                end
            end else begin
                out_valid <= in_fire;
                in_ready  <= 1'b1;
                if (in_fire) begin
                    main_q <= incoming;
                end
            end
        end else if (in_fire) begin
            skid_q     <= incoming;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

    assign result   = main_q.res;
    assign br_taken = main_q.br;
    assign illegal  = main_q.ill;
    assign out_tag  = main_q.tag;

endmodule
